// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   - Receiver FSM state encodings (3-bit constants, legacy-compatible).
//   - Oversampling / framing constants.
//   - Parity mismatch helper used by the optional parity stage.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef logic [2:0] state_t;

   localparam state_t IDLE   = 3'd0;
   localparam state_t START  = 3'd1;
   localparam state_t DATA   = 3'd2;
   localparam state_t PARITY = 3'd3;
   localparam state_t STOP   = 3'd4;
   localparam state_t BREAK  = 3'd5;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 8;
   localparam int DATA_BITS  = 8;

   // Tick-counter values at which a sample is taken (counter counts from 0).
   localparam logic [3:0] MID_TICK_LAST = 4'(MID_TICK - 1);
   localparam logic [3:0] OS_TICK_LAST  = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT      = 3'(DATA_BITS - 1);

   // Even parity: XOR of data and parity bit must be 0; odd parity: must be 1.
   function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                       input logic                 pbit,
                                       input logic                 odd);
      return ((^data) ^ pbit) != odd;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small show-ahead FIFO for received bytes.  The head entry is presented
// combinationally so the consumer sees data together with !empty.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (dropped when full unless popping this cycle)
//   push_data    byte to store
//   pop          remove head entry (ignored when empty)
//   head         current head entry (0 when empty)
//   full, empty  occupancy status
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   import uart_pkg::*;

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

   // A pop frees a slot in the same cycle, so a push while full still lands.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
      end
   end

   // Storage carries no reset; contents are only visible through valid pointers.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receive front-end: synchronises the raw RXD pin, detects start bits
// with 16x oversampling, deserialises 8N1 frames (LSB first) and buffers the
// bytes in a show-ahead FIFO with sticky error flags.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit stage
// (ports parity_en, parity_odd, parity_err).
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   divisor     oversample tick period minus 1 (16 ticks per bit)
//   rxd_in      raw serial input, idle high
//   rx_data     FIFO head byte
//   rx_valid    FIFO non-empty
//   rx_ready    pop request from consumer
//   frame_err   sticky: stop bit sampled low
//   overrun     sticky: byte dropped because FIFO full
//   err_clear   clears the sticky flags
//   parity_en   (UART_RX_PARITY_EN) enable parity bit
//   parity_odd  (UART_RX_PARITY_EN) 1 = odd parity, 0 = even
//   parity_err  (UART_RX_PARITY_EN) sticky: parity mismatch
//   busy        receiver not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int DIV_WIDTH   = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 rxd_in,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 err_clear,
`ifdef UART_RX_PARITY_EN
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic                 parity_err,
`endif
   output logic                 busy
);
   import uart_pkg::*;

   // ---------------------------------------------------------------- sync
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rxs;
   logic                   rxs_prev_reg;
   logic                   fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_reg     <= '1;
         rxs_prev_reg <= 1'b1;
      end else begin
         sync_reg     <= {sync_reg[SYNC_STAGES-2:0], rxd_in};
         rxs_prev_reg <= rxs;
      end
   end

   assign rxs  = sync_reg[SYNC_STAGES-1];
   assign fall = rxs_prev_reg && !rxs;

   // ----------------------------------------------------------- prescaler
   logic [DIV_WIDTH-1:0] presc_reg;
   logic [DIV_WIDTH-1:0] div_reg;
   logic                 tick;
   logic                 start_go;

   assign tick = (presc_reg == div_reg);

   // The divisor is captured at each wrap (and at frame start), so a new
   // value never truncates a period already in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_reg <= '0;
         div_reg   <= '0;
      end else if (start_go || tick) begin
         presc_reg <= '0;
         div_reg   <= divisor;
      end else begin
         presc_reg <= presc_reg + DIV_WIDTH'(1);
      end
   end

   // ----------------------------------------------------------------- FSM
   state_t                 state_reg,    state_next;
   logic [3:0]             tick_cnt_reg, tick_cnt_next;
   logic [2:0]             bit_cnt_reg,  bit_cnt_next;
   logic [DATA_BITS-1:0]   shift_reg,    shift_next;
   logic                   push;
   logic                   frame_set;
   logic                   parity_set;

   always_comb begin
      state_next    = state_reg;
      tick_cnt_next = tick_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      start_go      = 1'b0;
      push          = 1'b0;
      frame_set     = 1'b0;
      parity_set    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next    = START;
               tick_cnt_next = '0;
               start_go      = 1'b1;
            end
         end

         START: begin
            if (tick) begin
               if (tick_cnt_reg == MID_TICK_LAST) begin
                  tick_cnt_next = '0;
                  // Line back high at mid start bit: treat as a glitch.
                  if (rxs) begin
                     state_next = IDLE;
                  end else begin
                     state_next   = DATA;
                     bit_cnt_next = '0;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (tick_cnt_reg == OS_TICK_LAST) begin
                  tick_cnt_next = '0;
                  shift_next    = {rxs, shift_reg[DATA_BITS-1:1]};
                  if (bit_cnt_reg == LAST_BIT) begin
                     state_next = STOP;
`ifdef UART_RX_PARITY_EN
                     if (parity_en) begin
                        state_next = PARITY;
                     end
`endif
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 3'd1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (tick_cnt_reg == OS_TICK_LAST) begin
                  tick_cnt_next = '0;
                  parity_set    = parity_bad(shift_reg, rxs, parity_odd);
                  state_next    = STOP;
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end
`endif

         STOP: begin
            if (tick) begin
               if (tick_cnt_reg == OS_TICK_LAST) begin
                  tick_cnt_next = '0;
                  // Return to IDLE at mid stop bit so a following start edge
                  // right at the end of the stop bit is not missed.
                  if (rxs) begin
                     push       = 1'b1;
                     state_next = IDLE;
                  end else begin
                     frame_set  = 1'b1;
                     state_next = BREAK;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end

         BREAK: begin
            // Wait for the line to recover so a held-low line is one error.
            if (rxs) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         tick_cnt_reg <= tick_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
      end
   end

   // ---------------------------------------------------------------- FIFO
   logic fifo_full;
   logic fifo_empty;
   logic pop;
   logic overrun_set;

   assign pop         = rx_valid && rx_ready;
   assign overrun_set = push && fifo_full && !pop;

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shift_reg),
      .pop       (pop),
      .head      (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rx_valid = !fifo_empty;

   // -------------------------------------------------------- sticky flags
   logic frame_err_reg;
   logic overrun_reg;
   logic parity_err_reg;

   // An event in the same cycle as err_clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         frame_err_reg  <= frame_set   || (frame_err_reg  && !err_clear);
         overrun_reg    <= overrun_set || (overrun_reg    && !err_clear);
         parity_err_reg <= parity_set  || (parity_err_reg && !err_clear);
      end
   end

   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;
   assign busy      = (state_reg != IDLE);

`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_reg;
`else
   // Without a parity stage parity_set is constant 0; fold the register away.
   logic unused_parity;
   assign unused_parity = parity_err_reg;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive front-end sitting directly downstream of the chip input pin `uart0_rxd_in` (ui_in[7]); feeds the SoC's UART0 register block.
- Synchronises the asynchronous RXD line and detects start bits with 16x oversampling.
- Deserialises 8N1 frames, LSB first, and buffers received bytes in a small show-ahead FIFO with sticky error flags.
- The CPU-side register block pops bytes through a valid/ready interface.

Parameters:
- DIV_WIDTH, 16, width of the baud divisor input.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2, >= 2.
- SYNC_STAGES, 2, flip-flop stages in the RXD synchroniser; >= 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- divisor  in  DIV_WIDTH  oversample tick period minus 1 (tick every divisor+1 clocks; 16 ticks per bit)
- rxd_in  in  1  raw serial input, idle high
- rx_data  out  8  FIFO head byte
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop request from consumer
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte dropped because FIFO full
- err_clear  in  1  clears both sticky flags
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Synchroniser flops reset to 1.
  - State IDLE, prescaler 0, bit counter 0, FIFO empty.
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Synchroniser and edge detect:
  - Edge detection and sampling use only the last synchroniser stage (rxs).
  - Input-to-rxs latency is SYNC_STAGES cycles.
- Prescaler:
  - Free-running counter 0..divisor; `tick` is asserted for one cycle when counter == divisor, then counter wraps to 0.
  - Counter is forced to 0 on the IDLE->START transition.
  - divisor=0 gives a tick every clock.
  - divisor changes take effect at the next wrap.
- FSM:
  - IDLE: on rxs falling edge (prev 1, now 0) -> START; tick count := 0.
  - START: at the 8th tick, sample rxs (mid start bit).
    - If 1: false start, return to IDLE, nothing pushed.
    - If 0: go to DATA; bit index := 0; tick count := 0.
  - DATA: every 16th tick, sample rxs into shift register, LSB first. After bit 7 -> STOP.
  - STOP: at the 16th tick, sample rxs (mid stop bit).
    - If 1: push byte, go to IDLE immediately. No wait for end of stop bit, so back-to-back frames are supported.
    - If 0: set frame_err, discard byte, go to BREAK.
  - BREAK: stay until rxs==1, then go to IDLE. A held-low line yields exactly one frame_err and no spurious starts.
- FIFO (show-ahead):
  - rx_valid = !empty; rx_data = head entry.
  - Pop when rx_valid && rx_ready. A pop while empty is ignored.
  - Push result is visible on rx_valid the cycle after the stop-bit sample.
  - Push while full with no pop: byte dropped, overrun set.
  - Push and pop in the same cycle while full: both occur; overrun not set.
  - Push and pop in the same cycle while empty: push occurs, rx_valid=1 next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is handled by the MSB compare.
- Sticky flags:
  - Set by their event, cleared by err_clear.
  - Set and err_clear in the same cycle: set wins.
- Reset mid-frame: everything returns to reset values; a partial byte is discarded.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro defined:
  - Adds inputs parity_en and parity_odd (1 bit each), and sticky output parity_err (cleared by err_clear).
  - When parity_en=1, a PARITY state sits between DATA and STOP and samples the 16th tick.
  - On mismatch (even: XOR of data^bit must be 0; odd: must be 1), parity_err is set; the byte is still pushed if the stop bit is good.
- Without the macro: those ports and the PARITY state are absent; behaviour is 8N1 only.

Decomposition:
- Package uart_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Constants: OVERSAMPLE=16, MID_TICK=8, DATA_BITS=8.
- Sub-module uart_rx_fifo:
  - Parameters WIDTH, DEPTH.
  - Push/pop/full/empty/head.
  - Owns the simultaneous push/pop rules.

Test Plan:
- divisor=0, send 0xA5 as 8N1 (16 clocks/bit) -> rx_valid rises 1 cycle after the stop-bit sample; rx_data=0xA5; frame_err=0; busy low afterwards.
- divisor=3, send 0x00, 0xFF, 0x3C back-to-back with rx_ready=0 -> FIFO holds 3 bytes; pops return 0x00, 0xFF, 0x3C in order; rx_valid drops after the third pop.
- Send 5 bytes with rx_ready=0 and FIFO_DEPTH=4 -> first 4 retained, 5th dropped, overrun=1. Then pulse err_clear -> overrun=0.
- Low glitch of 4 clocks on rxd_in (divisor=0) -> false start, no push, busy returns 0.
- Frame 0x55 with stop bit forced low, then line held low for 40 bit times, then released -> frame_err=1 once, no push. Next valid frame 0x12 is received correctly.
- With UART_RX_PARITY_EN, parity_en=1, parity_odd=0: send 0x03 with parity bit 1 -> parity_err=1 and 0x03 is pushed. Repeat with parity bit 0 -> parity_err unchanged after err_clear (stays 0).
